// File: rtl/simple_median_top.sv
// Binary 3x3 majority filter over an internal 1-bit frame memory.
// Scans every centre, strobes each filtered pixel out and raises wakeUp on the ones count.
module simple_median_top #(
    parameter int IMG_W  = 240,
    parameter int IMG_H  = 180,
    parameter int ADDR_W = 8,
    parameter int THR_W  = 13,
    parameter int MAJ    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeMem,
    input  logic [ADDR_W-1:0] xAddressIn,
    input  logic [ADDR_W-1:0] yAddressIn,
    input  logic              dataIn,
    input  logic              start,
    input  logic [THR_W-1:0]  threshold,
    output logic              writeMedianMem,
    output logic [ADDR_W-1:0] xAddressOutMedianMem,
    output logic [ADDR_W-1:0] yAddressOutMedianMem,
    output logic              writeMedianData,
    output logic              wakeUp
);
    localparam int AW = $clog2(IMG_W * IMG_H);
    localparam logic [AW-1:0]     H_AW   = AW'(IMG_H);
    localparam logic [ADDR_W-1:0] X_LIM  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] Y_LIM  = ADDR_W'(IMG_H);
    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W:0]   NX_LIM = (ADDR_W+1)'(IMG_W);
    localparam logic [ADDR_W:0]   NY_LIM = (ADDR_W+1)'(IMG_H);
    localparam logic [3:0]        MAJ_C  = 4'(MAJ);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, EVAL, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [ADDR_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [8:0]        win_q, win_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              wake_q, wake_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] xo_q, xo_d, yo_q, yo_d;
    logic              do_q, do_d;

    logic              mem [0:IMG_W*IMG_H-1];
    logic              rd_q;
    logic [1:0]        kx, ky;
    logic [ADDR_W:0]   nx, ny;
    logic              in_img, wr_ok, maj;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [3:0]        ones;

    // Neighbour offsets are -1..+1; a -1 at the border wraps to a large value and fails the range check.
    always_comb begin
        kx      = 2'(k_q % 4'd3);
        ky      = 2'(k_q / 4'd3);
        nx      = {1'b0, cx_q} + {{(ADDR_W-1){1'b0}}, kx} - {{ADDR_W{1'b0}}, 1'b1};
        ny      = {1'b0, cy_q} + {{(ADDR_W-1){1'b0}}, ky} - {{ADDR_W{1'b0}}, 1'b1};
        in_img  = (nx < NX_LIM) && (ny < NY_LIM);
        rd_addr = AW'(nx[ADDR_W-1:0]) * H_AW + AW'(ny[ADDR_W-1:0]);
        wr_ok   = (state_q == IDLE) && writeMem && (xAddressIn < X_LIM) && (yAddressIn < Y_LIM);
        wr_addr = AW'(xAddressIn) * H_AW + AW'(yAddressIn);
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= dataIn;
        if (in_img)
            rd_q <= mem[rd_addr];
        else
            rd_q <= 1'b0;
    end

    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < 9; i++)
            ones = ones + {3'b000, win_q[i]};
        maj = (ones >= MAJ_C);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        wake_d  = wake_q;
        wr_d    = 1'b0;
        xo_d    = xo_q;
        yo_d    = yo_q;
        do_d    = do_q;
        case (state_q)
            IDLE: begin
                if (start && !writeMem) begin
                    state_d = READ;
                    k_d     = 4'd0;
                    cx_d    = '0;
                    cy_d    = '0;
                    cnt_d   = 16'd0;
                    wake_d  = 1'b0;
                end
            end
            READ: begin
                // rd_q lags the issued address by one cycle, so k=0 has nothing to shift yet.
                if (k_q != 4'd0)
                    win_d = {win_q[7:0], rd_q};
                if (k_q == 4'd8) begin
                    k_d     = 4'd0;
                    state_d = CAPTURE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            CAPTURE: begin
                win_d   = {win_q[7:0], rd_q};
                state_d = EVAL;
            end
            EVAL: begin
                wr_d = 1'b1;
                xo_d = cx_q;
                yo_d = cy_q;
                do_d = maj;
                if (maj && (cnt_q != 16'hFFFF))
                    cnt_d = cnt_q + 16'd1;
                state_d = READ;
                if (cy_q == Y_LAST) begin
                    cy_d = '0;
                    if (cx_q == X_LAST)
                        state_d = DONE;
                    else
                        cx_d = cx_q + 1'b1;
                end else begin
                    cy_d = cy_q + 1'b1;
                end
            end
            DONE: begin
                wake_d = (cnt_q > {{(16-THR_W){1'b0}}, threshold});
                if (!start)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= 4'd0;
            cx_q    <= '0;
            cy_q    <= '0;
            win_q   <= 9'd0;
            cnt_q   <= 16'd0;
            wake_q  <= 1'b0;
            wr_q    <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
            do_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            wake_q  <= wake_d;
            wr_q    <= wr_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            do_q    <= do_d;
        end
    end

    assign writeMedianMem       = wr_q;
    assign xAddressOutMedianMem = xo_q;
    assign yAddressOutMedianMem = yo_q;
    assign writeMedianData      = do_q;
    assign wakeUp               = wake_q;
endmodule

// File: tb/tb_simple_median_top.sv
// Scoreboard bench for simple_median_top on a reduced 24x18 frame.
module tb_simple_median_top;
    localparam int W = 24;
    localparam int H = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       writeMem = 1'b0;
    logic [7:0] xAddressIn = 8'd0;
    logic [7:0] yAddressIn = 8'd0;
    logic       dataIn = 1'b0;
    logic       start = 1'b0;
    logic [12:0] threshold = 13'd0;
    logic       writeMedianMem;
    logic [7:0] xAddressOutMedianMem;
    logic [7:0] yAddressOutMedianMem;
    logic       writeMedianData;
    logic       wakeUp;

    simple_median_top #(.IMG_W(W), .IMG_H(H)) dut (
        .clk                  (clk),
        .reset                (reset),
        .writeMem             (writeMem),
        .xAddressIn           (xAddressIn),
        .yAddressIn           (yAddressIn),
        .dataIn               (dataIn),
        .start                (start),
        .threshold            (threshold),
        .writeMedianMem       (writeMedianMem),
        .xAddressOutMedianMem (xAddressOutMedianMem),
        .yAddressOutMedianMem (yAddressOutMedianMem),
        .writeMedianData      (writeMedianData),
        .wakeUp               (wakeUp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    x;
        int    y;
        bit    d;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    bit     img [0:W-1][0:H-1];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe pops one expected pixel, including its cycle of arrival.
    always @(negedge clk) begin
        if (reset && writeMedianMem) begin
            chk("strobe_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("strobe x=%0d y=%0d d=%0d cyc=%0d", xAddressOutMedianMem,
                         yAddressOutMedianMem, writeMedianData, cyc);
                chk("x", 64'(xAddressOutMedianMem), 64'(e.x));
                chk("y", 64'(yAddressOutMedianMem), 64'(e.y));
                chk("data", 64'(writeMedianData), 64'(e.d));
                chk("cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic load_img();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++) begin
                writeMem   = 1'b1;
                xAddressIn = 8'(x);
                yAddressIn = 8'(y);
                dataIn     = img[x][y];
                tick();
            end
        writeMem = 1'b0;
        tick();
    endtask

    task automatic fill(input bit v);
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                img[x][y] = v;
    endtask

    // Model: majority of the in-image neighbours, scan x outer, y inner.
    task automatic start_pass(input int thr);
        longint t;
        int idx;
        threshold = 13'(thr);
        t = cyc + 1;
        idx = 0;
        exp_cnt = 0;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++) begin
                int s;
                exp_t e;
                s = 0;
                for (int dx = -1; dx <= 1; dx++)
                    for (int dy = -1; dy <= 1; dy++)
                        if (x+dx >= 0 && x+dx < W && y+dy >= 0 && y+dy < H)
                            s += int'(img[x+dx][y+dy]);
                e.x = x; e.y = y; e.d = (s >= 5); e.cyc = t + 11*(idx+1);
                if (e.d) exp_cnt++;
                sb.push_back(e);
                idx++;
            end
        start = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("pass_complete", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic finish_pass(input int thr, input string tag);
        drain(W*H*11 + 200);
        tick(3);
        chk(tag, 64'(wakeUp), 64'(exp_cnt > thr));
        tick(20);
    endtask

    task automatic end_pass();
        start = 1'b0;
        tick(3);
    endtask

    initial begin
        int total;
        tick(3);
        chk("rst_wr", 64'(writeMedianMem), 64'd0);
        chk("rst_x", 64'(xAddressOutMedianMem), 64'd0);
        chk("rst_y", 64'(yAddressOutMedianMem), 64'd0);
        chk("rst_data", 64'(writeMedianData), 64'd0);
        chk("rst_wake", 64'(wakeUp), 64'd0);
        reset = 1'b1;
        tick(2);

        // All zeros; out-of-range writes of 1 must not land anywhere.
        fill(1'b0);
        load_img();
        writeMem = 1'b1; dataIn = 1'b1;
        xAddressIn = 8'(W); yAddressIn = 8'd0; tick();
        xAddressIn = 8'd0;  yAddressIn = 8'(H); tick();
        writeMem = 1'b0; dataIn = 1'b0; tick();
        start_pass(50);
        finish_pass(50, "wake_zeros");
        end_pass();

        fill(1'b1);
        load_img();
        start_pass(50);
        chk("model_ones_count", 64'(exp_cnt), 64'(W*H-4));
        finish_pass(50, "wake_ones");
        end_pass();

        fill(1'b0);
        img[10][9] = 1'b1;
        load_img();
        start_pass(0);
        finish_pass(0, "wake_isolated");
        end_pass();

        fill(1'b0);
        for (int x = 10; x <= 12; x++)
            for (int y = 5; y <= 7; y++)
                img[x][y] = 1'b1;
        load_img();
        start_pass(4);
        chk("model_block_count", 64'(exp_cnt), 64'd5);
        finish_pass(4, "wake_block_thr4");
        threshold = 13'd5;
        tick(2);
        chk("wake_block_thr5", 64'(wakeUp), 64'd0);
        end_pass();

        // Random image, ignored writes during the scan, then reset mid-scan and a rerun.
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                img[x][y] = 1'($urandom_range(0, 1));
        load_img();
        start_pass(100);
        total = W*H;
        begin
            int n;
            n = 0;
            while (sb.size() > total - 20 && n < 2000) begin tick(); n++; end
            for (int i = 0; i < 6; i++) begin
                writeMem = 1'b1; xAddressIn = 8'(i); yAddressIn = 8'(i); dataIn = ~img[i][i];
                tick();
            end
            writeMem = 1'b0;
            n = 0;
            while (sb.size() > total - 100 && n < 2000) begin tick(); n++; end
            chk("reached_mid_scan", 64'(sb.size() <= total - 100), 64'd1);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("mid_rst_wr", 64'(writeMedianMem), 64'd0);
        chk("mid_rst_x", 64'(xAddressOutMedianMem), 64'd0);
        chk("mid_rst_y", 64'(yAddressOutMedianMem), 64'd0);
        chk("mid_rst_data", 64'(writeMedianData), 64'd0);
        chk("mid_rst_wake", 64'(wakeUp), 64'd0);
        reset = 1'b1;
        sb.delete();
        tick(40);
        start_pass(100);
        finish_pass(100, "wake_rerun");
        end_pass();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/simple_median_top.md
Name: simple_median_top

Overview:
- Binary 3x3 median (majority) filter for a 240x180 image of 1-bit pixels, held in internal frame memory.
- Host loads the image pixel by pixel, then asserts start.
- The block scans every pixel, emits one filtered pixel per centre on a write-strobe interface toward a downstream median memory, and counts filtered "1" pixels.
- wakeUp is raised when that count exceeds a programmable threshold.

Parameters:
- IMG_W, 240, image width (x range 0..IMG_W-1).
- IMG_H, 180, image height (y range 0..IMG_H-1).
- ADDR_W, 8, coordinate width.
- THR_W, 13, threshold width.
- MAJ, 5, minimum ones in the 3x3 window for output 1.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- writeMem  in  1  load-mode write enable for frame memory.
- xAddressIn  in  8  load x coordinate.
- yAddressIn  in  8  load y coordinate.
- dataIn  in  1  load pixel value.
- start  in  1  level request to run one filter pass.
- threshold  in  13  wakeUp threshold, unsigned.
- writeMedianMem  out  1  one-cycle strobe: filtered pixel valid.
- xAddressOutMedianMem  out  8  x of filtered pixel.
- yAddressOutMedianMem  out  8  y of filtered pixel.
- writeMedianData  out  1  filtered pixel value.
- wakeUp  out  1  filtered ones count > threshold after a completed pass.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low.
- Reset (reset=0 at a clk edge):
  - All outputs 0.
  - FSM to IDLE.
  - Scan coordinates, neighbour counter, window register and ones count cleared.
  - Frame memory contents retained, not cleared.
- Load:
  - While writeMem=1 in IDLE, each cycle writes dataIn to mem[x][y].
  - Writes with x>=240 or y>=180 are ignored.
  - Written data is visible from the next cycle.
  - writeMem is ignored outside IDLE.
- FSM states: IDLE, READ, CAPTURE, EVAL, DONE.
- IDLE:
  - Transition to READ when start=1 and writeMem=0.
  - On entry, clear the ones count, clear wakeUp, and set centre=(0,0).
- READ: 4-bit counter k=0..8 selects neighbour (cx+(k mod 3)-1, cy+(k div 3)-1).
  - One synchronous memory read per cycle, 1-cycle latency.
  - Out-of-image neighbours read as 0.
  - Returned bits shift into a 9-entry window register dataFIFO[0..8].
  - After k=8, go to CAPTURE.
- CAPTURE: take the last read datum (window complete), go to EVAL.
- EVAL (exactly one cycle):
  - ones = popcount(window).
  - Drive writeMedianMem=1, writeMedianData=(ones>=MAJ), x/yAddressOutMedianMem = centre.
  - If data=1, increment the ones count (16-bit, saturating).
  - Advance the centre with y inner (0..179) and x outer (0..239), then go back to READ.
  - After centre (239,179), go to DONE instead.
- Timing: 11 cycles per pixel, 43200 strobes per pass. The first strobe (0,0) occurs 11 cycles after the cycle in which start is sampled.
- Output hold between strobes:
  - writeMedianMem=0.
  - Address/data outputs hold their last values.
- DONE:
  - wakeUp <= (count > threshold), compared unsigned with threshold zero-extended.
  - Held until the next pass starts or reset.
  - Stay in DONE while start=1; return to IDLE when start=0.
  - A continuously held start therefore yields exactly one pass.
- threshold is sampled only in DONE; changes during a scan do not matter.
- Reset mid-scan: abort immediately, outputs 0, no further strobes, memory intact. A later start reruns the full pass from (0,0).
- start deasserted mid-scan: no effect; the pass completes.

Test Plan:
- Reset, load all 43200 pixels = 0, threshold=50, start=1 → 43200 strobes in order (0,0),(0,1)…(239,179); every writeMedianData=0; wakeUp=0 in DONE.
- Load all ones, threshold=50 → the 4 corners (window ones=4) give 0, all other pixels give 1; count=43196; wakeUp=1.
- Load zeros plus one isolated 1 at (100,90) → all outputs 0 (salt noise removed); wakeUp=0 with threshold=0.
- Load zeros plus a 3x3 block of ones at x=10..12, y=20..22 → data=1 only at (11,21),(10,21),(12,21),(11,20),(11,22); count=5. threshold=4 gives wakeUp=1; threshold=5 gives wakeUp=0.
- Strobe timing: start sampled at cycle T → writeMedianMem high only at T+11, T+22, …; the strobe at T+11 carries (0,0), the one at T+22 carries (0,1).
- Assert reset=0 for one cycle mid-scan (≈ strobe 1000) → outputs 0 immediately, FSM IDLE; a new start reproduces the identical full result (memory retained); writeMem pulses during the scan do not alter results.
